// File: rtl/fre_pkg.sv
// Shared constants, FSM encoding and the load range check for the square-wave generator.
package fre_pkg;

    localparam int unsigned CLK_HZ  = 50_000_000;
    localparam int unsigned CLK_KHZ = 50_000;
    localparam int unsigned PW      = 26;
    localparam int unsigned FW      = 20;

    localparam logic [FW-1:0] KHZ_MAX = 20'd25_000;

    typedef enum logic [2:0] {
        IDLE = 3'b001,
        CALC = 3'b010,
        RUN  = 3'b100
    } state_t;

    // Zero is never legal; the kHz ceiling keeps the period at two cycles or more.
    function automatic logic fre_legal(input logic [FW-1:0] val, input logic low_sel);
        return (val != '0) && (low_sel || (val <= KHZ_MAX));
    endfunction

endpackage

// File: rtl/fre_div_seq.sv
// Sequential restoring divider, one quotient bit per cycle; done pulses PW+1 cycles after start.
module fre_div_seq #(
    parameter int unsigned PW = 26
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [PW-1:0] numer,
    input  logic [PW-1:0] denom,
    output logic [PW-1:0] quotient,
    output logic          done
);

    localparam int unsigned SW = $clog2(PW + 1);

    logic [PW-1:0] rem_q;
    logic [PW-1:0] quo_q;
    logic [PW-1:0] den_q;
    logic [SW-1:0] step_q;
    logic          active_q;
    logic [PW:0]   shifted;
    logic [PW:0]   diff;

    // shifted < 2*den, so the signed difference always fits in PW+1 bits.
    always_comb begin
        shifted = {rem_q, quo_q[PW-1]};
        diff    = shifted - {1'b0, den_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q    <= '0;
            quo_q    <= '0;
            den_q    <= '0;
            step_q   <= '0;
            active_q <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem_q    <= '0;
                quo_q    <= numer;
                den_q    <= denom;
                step_q   <= '0;
                active_q <= 1'b1;
            end else if (active_q) begin
                if (step_q == SW'(PW)) begin
                    active_q <= 1'b0;
                    done     <= 1'b1;
                end else begin
                    quo_q  <= {quo_q[PW-2:0], ~diff[PW]};
                    rem_q  <= diff[PW] ? shifted[PW-1:0] : diff[PW-1:0];
                    step_q <= step_q + SW'(1);
                end
            end
        end
    end

    assign quotient = quo_q;

endmodule

// File: rtl/fre_gen.sv
// Programmable square-wave generator: range check, period divider, FSM and
// runt-free phase counter driving a registered ~50% duty output.
module fre_gen #(
    parameter int unsigned CLK_HZ  = fre_pkg::CLK_HZ,
    parameter int unsigned CLK_KHZ = fre_pkg::CLK_KHZ,
    parameter int unsigned PW      = fre_pkg::PW
) (
    input  logic          clk_i,
    input  logic          rst_n,
    input  logic          load_i,
    input  logic [19:0]   fre_val_i,
    input  logic          low_fre_sel_i,
    input  logic          en_i,
    output logic          fre_o,
    output logic          busy_o,
    output logic          err_o,
    output logic [PW-1:0] period_o
);

    import fre_pkg::state_t;
    import fre_pkg::IDLE;
    import fre_pkg::CALC;
    import fre_pkg::RUN;
    import fre_pkg::fre_legal;

    state_t        state_q;
    state_t        state_d;
    logic          load_ok;
    logic          load_zero;
    logic          accept;
    logic          run;
    logic [PW-1:0] numer;
    logic [PW-1:0] denom;
    logic [PW-1:0] quotient;
    logic          div_done;
    logic [PW-1:0] period_q;
    logic [PW-1:0] pend_q;
    logic          pend_vld_q;
    logic [PW-1:0] cnt_q;
    logic [PW-1:0] high_len;
    logic          fre_q;
    logic          err_q;

    always_comb begin
        load_ok   = load_i && fre_legal(fre_val_i, low_fre_sel_i);
        load_zero = load_i && (fre_val_i == '0);
        // A load landing on the done cycle restarts the divider, so its result is dropped.
        accept    = div_done && (state_q == CALC) && !load_ok && !load_zero;
        numer     = low_fre_sel_i ? PW'(CLK_HZ) : PW'(CLK_KHZ);
        denom     = PW'(fre_val_i);
        high_len  = period_q - (period_q >> 1);
        run       = en_i && (state_q != IDLE) && ((period_q != '0) || pend_vld_q);
    end

    fre_div_seq #(
        .PW(PW)
    ) u_div (
        .clk      (clk_i),
        .rst_n    (rst_n),
        .start    (load_ok),
        .numer    (numer),
        .denom    (denom),
        .quotient (quotient),
        .done     (div_done)
    );

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (load_zero) begin
            state_d = IDLE;
        end else if (load_ok) begin
            state_d = CALC;
        end else if (accept) begin
            state_d = RUN;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (load_i) begin
            err_q <= !load_ok;
        end
    end

    // New periods wait in pend_q and are applied only at cnt==0, the low->high boundary.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            fre_q      <= 1'b0;
            cnt_q      <= '0;
            period_q   <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
        end else if (load_zero) begin
            fre_q      <= 1'b0;
            cnt_q      <= '0;
            period_q   <= '0;
            pend_vld_q <= 1'b0;
        end else begin
            if (!run) begin
                fre_q <= 1'b0;
                cnt_q <= '0;
            end else if (cnt_q == '0) begin
                fre_q <= 1'b1;
                cnt_q <= PW'(1);
                if (pend_vld_q) begin
                    period_q   <= pend_q;
                    pend_vld_q <= 1'b0;
                end
            end else begin
                fre_q <= (cnt_q < high_len);
                cnt_q <= (cnt_q == period_q - PW'(1)) ? '0 : cnt_q + PW'(1);
            end
            if (accept) begin
                pend_q     <= quotient;
                pend_vld_q <= 1'b1;
            end
        end
    end

    assign fre_o    = fre_q;
    assign busy_o   = (state_q == CALC);
    assign err_o    = err_q;
    assign period_o = period_q;

endmodule

// File: tb/tb_fre_gen.sv
// Directed bench for fre_gen: period values, busy length, phase lengths, retune, errors, enable, reset.
module tb_fre_gen;

    logic        clk_i = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_i = 1'b0;
    logic [19:0] fre_val_i = '0;
    logic        low_fre_sel_i = 1'b0;
    logic        en_i = 1'b0;
    logic        fre_o;
    logic        busy_o;
    logic        err_o;
    logic [25:0] period_o;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk_i = ~clk_i;

    fre_gen #(
        .CLK_HZ (50_000_000),
        .CLK_KHZ(50_000),
        .PW     (26)
    ) dut (
        .clk_i        (clk_i),
        .rst_n        (rst_n),
        .load_i       (load_i),
        .fre_val_i    (fre_val_i),
        .low_fre_sel_i(low_fre_sel_i),
        .en_i         (en_i),
        .fre_o        (fre_o),
        .busy_o       (busy_o),
        .err_o        (err_o),
        .period_o     (period_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the load edge.
    task automatic do_load(input logic [19:0] v, input logic low);
        load_i        = 1'b1;
        fre_val_i     = v;
        low_fre_sel_i = low;
        @(negedge clk_i);
        load_i = 1'b0;
    endtask

    task automatic busy_len(output int unsigned n);
        n = 0;
        while (busy_o && n < 100) begin
            n++;
            @(negedge clk_i);
        end
    endtask

    task automatic run_len(input logic lvl, input int unsigned limit, output int unsigned n);
        n = 0;
        while (fre_o == lvl && n < limit) begin
            n++;
            @(negedge clk_i);
        end
    endtask

    initial begin
        int unsigned n;
        int unsigned hi;

        repeat (3) @(negedge clk_i);
        check("rst_fre", 32'(fre_o), 0);
        check("rst_busy", 32'(busy_o), 0);
        check("rst_err", 32'(err_o), 0);
        check("rst_period", 32'(period_o), 0);
        rst_n = 1'b1;
        en_i  = 1'b1;
        @(negedge clk_i);

        // kHz 1 from idle, then retune to kHz 10 mid high phase
        do_load(20'd1, 1'b0);
        check("k1_err", 32'(err_o), 0);
        busy_len(n);
        check("k1_busy_len", n, 28);
        check("k1_pre_edge", 32'(fre_o), 0);
        @(negedge clk_i);
        check("k1_first_high", 32'(fre_o), 1);
        check("k1_period", 32'(period_o), 50_000);
        hi = 0;
        while (fre_o && hi < 30_000) begin
            hi++;
            load_i        = (hi == 1000);
            fre_val_i     = 20'd10;
            low_fre_sel_i = 1'b0;
            @(negedge clk_i);
        end
        load_i = 1'b0;
        check("k1_high", hi, 25_000);
        check("retune_old_period", 32'(period_o), 50_000);
        run_len(1'b0, 30_000, n);
        check("k1_low", n, 25_000);
        check("retune_period", 32'(period_o), 5_000);
        run_len(1'b1, 3_000, n);
        check("retune_high", n, 2_500);
        run_len(1'b0, 3_000, n);
        check("retune_low", n, 2_500);

        // zero load stops output
        do_load(20'd0, 1'b0);
        check("zero_err", 32'(err_o), 1);
        check("zero_fre", 32'(fre_o), 0);
        check("zero_period", 32'(period_o), 0);
        check("zero_busy", 32'(busy_o), 0);

        // odd period
        do_load(20'd17, 1'b0);
        check("k17_err", 32'(err_o), 0);
        busy_len(n);
        check("k17_busy_len", n, 28);
        @(negedge clk_i);
        check("k17_period", 32'(period_o), 2_941);
        run_len(1'b1, 2_000, n);
        check("k17_high", n, 1_471);
        run_len(1'b0, 2_000, n);
        check("k17_low", n, 1_470);

        // enable drop and restart
        en_i = 1'b0;
        @(negedge clk_i);
        check("en_off_fre", 32'(fre_o), 0);
        repeat (5) @(negedge clk_i);
        check("en_off_hold", 32'(fre_o), 0);
        check("en_off_period", 32'(period_o), 2_941);
        en_i = 1'b1;
        @(negedge clk_i);
        check("en_on_fre", 32'(fre_o), 1);
        run_len(1'b1, 2_000, n);
        check("en_on_high", n, 1_471);

        // out-of-range load while running in the low phase
        do_load(20'd25_001, 1'b0);
        check("oor_err", 32'(err_o), 1);
        check("oor_period", 32'(period_o), 2_941);
        check("oor_busy", 32'(busy_o), 0);
        check("oor_fre", 32'(fre_o), 0);
        run_len(1'b0, 2_000, n);
        check("oor_low_rest", n, 1_469);

        // maximum rate
        do_load(20'd25_000, 1'b0);
        check("max_err", 32'(err_o), 0);
        n = 0;
        while (period_o != 26'd2 && n < 4_000) begin
            n++;
            @(negedge clk_i);
        end
        check("max_period", 32'(period_o), 2);
        check("max_first", 32'(fre_o), 1);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk_i);
            check("max_toggle", 32'(fre_o), (i % 2 == 0) ? 1 : 0);
        end

        // Hz mode 1000
        do_load(20'd1000, 1'b1);
        busy_len(n);
        check("hz_busy_len", n, 28);
        n = 0;
        while (period_o == 26'd2 && n < 10) begin
            n++;
            @(negedge clk_i);
        end
        check("hz_period", 32'(period_o), 50_000);
        check("hz_fre", 32'(fre_o), 1);

        // asynchronous reset mid-run with err set
        do_load(20'd30_000, 1'b0);
        check("pre_rst_err", 32'(err_o), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_fre", 32'(fre_o), 0);
        check("arst_busy", 32'(busy_o), 0);
        check("arst_err", 32'(err_o), 0);
        check("arst_period", 32'(period_o), 0);
        @(negedge clk_i);
        rst_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
